// File: rtl/control_seq_pkg.sv
// Shared types for the accumulator CPU control path: opcodes, sequencer
// phases and the opcode classification used by the phase decode.
package typedefs;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/control_seq.sv
// Instruction sequencer: an 8-phase state machine per instruction that
// decodes (phase, opcode, zero, halted) into memory, IR, PC and AC strobes.
module control_seq
    import typedefs::*;
#(
    parameter int NUM_PHASES = 8
) (
    input  logic       clk,
    input  logic       rst_,
    input  opcode_t    opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ac,
    output logic       halt,
    output logic [2:0] phase
);

    // The phase encoding is hard-wired to a 3-bit wrap; refuse anything else.
    if (NUM_PHASES != 8) begin : g_bad_phases
        $error("control_seq: NUM_PHASES must be 8");
    end

    state_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;

    assign aluop = is_aluop(opcode);
    assign phase = phase_q;

    // Phase and halt state; reset wins over both advancing and halting.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-phase and strobe decode; while reset is held every strobe is 0.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        load_ir  = 1'b0;
        inc_pc   = 1'b0;
        load_pc  = 1'b0;
        load_ac  = 1'b0;
        halt     = 1'b0;

        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    phase_d = INST_FETCH;
                end
                INST_FETCH: begin
                    mem_rd  = 1'b1;
                    phase_d = INST_LOAD;
                end
                INST_LOAD: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                    phase_d = IDLE;
                end
                IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                    phase_d = OP_ADDR;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                    if (opcode == HLT) begin
                        halted_d = 1'b1;
                        phase_d  = OP_ADDR;
                    end else begin
                        phase_d  = OP_FETCH;
                    end
                end
                OP_FETCH: begin
                    mem_rd  = aluop;
                    phase_d = ALU_OP;
                end
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                    phase_d = STORE;
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                    phase_d = INST_ADDR;
                end
                default: begin
                    phase_d = INST_ADDR;
                end
            endcase
        end

        if (!rst_) begin
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            load_ir = 1'b0;
            inc_pc  = 1'b0;
            load_pc = 1'b0;
            load_ac = 1'b0;
            halt    = 1'b0;
        end
    end

endmodule
